// File: rtl/fifo_uart_tx_if.sv
// Read-side bundle between the TX FIFO and the UART serializer.
// master = serializer (issues the pop), slave = FIFO (supplies data and empty flag).
interface fifo_uart_tx_if;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd_en;

    modport master (input fifo_empty, input fifo_dout, output fifo_rd_en);
    modport slave  (output fifo_empty, output fifo_dout, input fifo_rd_en);
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a registered-read FIFO and sends them as 8N1 UART frames, LSB first.
//
// state | meaning
// IDLE  | line high, waiting for enable with a non-empty FIFO
// POP   | one-cycle rd_en strobe to the FIFO
// LOAD  | FIFO data now valid; capture {stop, data, start} into the shift register
// SEND  | shift the frame out, one bit per SYMBOL_EDGE_TIME cycles
module fifo_uart_tx #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_enable,
    fifo_uart_tx_if.master fifo,
    output logic           o_serial_out,
    output logic           o_busy
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_WIDTH        = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam logic [CNT_WIDTH-1:0] BAUD_TC  = CNT_WIDTH'(SYMBOL_EDGE_TIME - 1);
    localparam logic [3:0]           LAST_BIT = 4'd9;

    typedef enum logic [1:0] {IDLE, POP, LOAD, SEND} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [9:0]           r_shift;
    logic [CNT_WIDTH-1:0] r_baud;
    logic [3:0]           r_bit;
    logic                 w_tc;

    assign w_tc = (r_baud == BAUD_TC);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        fifo.fifo_rd_en = 1'b0;
        o_busy          = 1'b1;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_enable && !fifo.fifo_empty) begin
                    w_next = POP;
                end
            end
            POP: begin
                fifo.fifo_rd_en = 1'b1;
                w_next          = LOAD;
            end
            LOAD: w_next = SEND;
            SEND: begin
                if (w_tc && (r_bit == LAST_BIT)) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Shift register refills with ones, so it is all ones outside SEND and drives the pin directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '1;
            r_baud  <= '0;
            r_bit   <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_shift <= {1'b1, fifo.fifo_dout, 1'b0};
                    r_baud  <= '0;
                    r_bit   <= '0;
                end
                SEND: begin
                    if (w_tc) begin
                        r_shift <= {1'b1, r_shift[9:1]};
                        r_baud  <= '0;
                        r_bit   <= (r_bit == LAST_BIT) ? 4'd0 : r_bit + 4'd1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_baud <= r_baud;
                end
            endcase
        end
    end

    assign o_serial_out = r_shift[0];

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: registered-read FIFO model, line decoder
// reference, table-driven frames, hand-written corner sequences and a randomized run.
module tb_fifo_uart_tx;
    localparam int CLOCK_FREQ = 1000;
    localparam int BAUD_RATE  = 100;
    localparam int S          = CLOCK_FREQ / BAUD_RATE;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic enable = 1'b1;
    logic serial_out;
    logic busy;

    fifo_uart_tx_if ifc();

    fifo_uart_tx #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (enable),
        .fifo         (ifc),
        .o_serial_out (serial_out),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // FIFO model: dout registered on the rd_en edge, no reset (a pop is never undone).
    logic [7:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign ifc.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (ifc.fifo_rd_en) begin
            ifc.fifo_dout <= mem[rd_ptr[7:0]];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    // Protocol monitor.
    int rd_cnt    = 0;
    int proto_err = 0;
    logic prev_rd = 1'b0;
    always @(negedge clk) begin
        if (ifc.fifo_rd_en) begin
            rd_cnt = rd_cnt + 1;
            if (ifc.fifo_empty) proto_err = proto_err + 1;
            if (prev_rd) proto_err = proto_err + 1;
        end
        prev_rd = ifc.fifo_rd_en;
    end

    // Reference decoder: samples the middle of every bit after a falling start edge.
    logic [7:0] dec_q [$];
    int         dec_t [$];
    logic [7:0] exp_q [$];
    int         dec_err = 0;
    bit         dec_en  = 1'b1;
    int         cyc     = 0;
    logic [7:0] dec_b;
    logic       dec_ok;
    int         dec_t0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            if (dec_en && !rst && serial_out === 1'b0) begin
                dec_t0 = cyc;
                dec_ok = 1'b1;
                repeat (S / 2) @(negedge clk);
                if (serial_out !== 1'b0) dec_ok = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    repeat (S) @(negedge clk);
                    dec_b[k] = serial_out;
                end
                repeat (S) @(negedge clk);
                if (serial_out !== 1'b1) dec_ok = 1'b0;
                dec_q.push_back(dec_b);
                dec_t.push_back(dec_t0);
                if (!dec_ok) dec_err = dec_err + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    function automatic logic [9:0] frame_of(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    task automatic wait_pop(input string name, input int limit);
        bit got;
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (ifc.fifo_rd_en) begin
                got = 1'b1;
                break;
            end
        end
        chk({name, "_pop_seen"}, int'(got), 1);
    endtask

    // Entered on the POP-cycle negedge; ends on the IDLE-cycle negedge after the stop bit.
    task automatic check_frame(input string name, input logic [9:0] exp, input int drop_at);
        int bad;
        @(negedge clk);
        chk({name, "_load_line"}, int'(serial_out), 1);
        chk({name, "_load_busy"}, int'(busy), 1);
        chk({name, "_load_rd_en"}, int'(ifc.fifo_rd_en), 0);
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int c = 0; c < S; c++) begin
                @(negedge clk);
                if (serial_out !== exp[b] || busy !== 1'b1 || ifc.fifo_rd_en !== 1'b0) bad++;
                if (b * S + c == drop_at) enable = 1'b0;
            end
            chk($sformatf("%s_bit%0d_bad_cycles", name, b), bad, 0);
        end
        @(negedge clk);
        chk({name, "_idle_busy"}, int'(busy), 0);
        chk({name, "_idle_line"}, int'(serial_out), 1);
    endtask

    task automatic cmp_decoded(input string name);
        chk({name, "_decoded_count"}, dec_q.size(), exp_q.size());
        while (exp_q.size() > 0 && dec_q.size() > 0) begin
            chk({name, "_decoded_byte"}, int'(dec_q.pop_front()), int'(exp_q.pop_front()));
        end
        dec_q.delete();
        exp_q.delete();
        dec_t.delete();
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, want normal end");
        $fatal(1);
    end

    initial begin
        int r0;
        int bad_line, bad_rd, bad_busy;
        int n, pushed;
        logic [7:0] rb;

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h3C, 10'b1001111000};
        vecs[4] = '{8'h5A, 10'b1010110100};

        // Reset and idle with empty FIFO
        @(negedge clk);
        chk("reset_line", int'(serial_out), 1);
        chk("reset_rd_en", int'(ifc.fifo_rd_en), 0);
        chk("reset_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad_line = 0; bad_rd = 0; bad_busy = 0;
        repeat (100) begin
            @(negedge clk);
            if (serial_out !== 1'b1) bad_line++;
            if (ifc.fifo_rd_en !== 1'b0) bad_rd++;
            if (busy !== 1'b0) bad_busy++;
        end
        chk("idle_line_low_cycles", bad_line, 0);
        chk("idle_rd_en_cycles", bad_rd, 0);
        chk("idle_busy_cycles", bad_busy, 0);

        // Table of single frames
        for (int i = 0; i < 5; i++) begin
            r0 = rd_cnt;
            exp_q.push_back(vecs[i].data);
            push(vecs[i].data);
            wait_pop($sformatf("vec%0d", i), 20);
            check_frame($sformatf("vec%0d", i), vecs[i].frame, -1);
            chk($sformatf("vec%0d_rd_pulses", i), rd_cnt - r0, 1);
        end
        repeat (5) @(negedge clk);
        cmp_decoded("table");

        // Back-to-back frames
        r0 = rd_cnt;
        push(8'h00); push(8'hFF); push(8'h3C);
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h3C);
        wait_pop("b2b0", 20);
        check_frame("b2b0", frame_of(8'h00), -1);
        @(negedge clk);
        chk("b2b1_pop_right_after_idle", int'(ifc.fifo_rd_en), 1);
        check_frame("b2b1", frame_of(8'hFF), -1);
        @(negedge clk);
        chk("b2b2_pop_right_after_idle", int'(ifc.fifo_rd_en), 1);
        check_frame("b2b2", frame_of(8'h3C), -1);
        repeat (5) @(negedge clk);
        chk("b2b_rd_pulses", rd_cnt - r0, 3);
        chk("b2b_fifo_empty", int'(ifc.fifo_empty), 1);
        chk("b2b_frames", dec_t.size(), 3);
        if (dec_t.size() == 3) begin
            chk("b2b_start_spacing01", dec_t[1] - dec_t[0], 10 * S + 3);
            chk("b2b_start_spacing12", dec_t[2] - dec_t[1], 10 * S + 3);
        end
        cmp_decoded("b2b");

        // Enable gating
        enable = 1'b0;
        r0 = rd_cnt;
        push(8'h55); push(8'h66);
        bad_line = 0; bad_rd = 0;
        repeat (500) begin
            @(negedge clk);
            if (serial_out !== 1'b1) bad_line++;
            if (ifc.fifo_rd_en !== 1'b0) bad_rd++;
        end
        chk("gated_line_low_cycles", bad_line, 0);
        chk("gated_rd_en_cycles", bad_rd, 0);
        enable = 1'b1;
        @(negedge clk);
        chk("enable_pop_latency", int'(ifc.fifo_rd_en), 1);
        exp_q.push_back(8'h55);
        check_frame("en55", frame_of(8'h55), 4 * S + 5);
        bad_line = 0; bad_rd = 0;
        repeat (200) begin
            @(negedge clk);
            if (serial_out !== 1'b1) bad_line++;
            if (ifc.fifo_rd_en !== 1'b0) bad_rd++;
        end
        chk("disabled_line_low_cycles", bad_line, 0);
        chk("disabled_rd_en_cycles", bad_rd, 0);
        chk("disabled_fifo_still_holds", int'(ifc.fifo_empty), 0);
        chk("enable_rd_pulses", rd_cnt - r0, 1);
        enable = 1'b1;
        exp_q.push_back(8'h66);
        wait_pop("en66", 20);
        check_frame("en66", frame_of(8'h66), -1);
        repeat (5) @(negedge clk);
        cmp_decoded("enable");

        // Reset during data bit 4
        dec_en = 1'b0;
        push(8'h81);
        wait_pop("rst81", 20);
        repeat (55) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_line", int'(serial_out), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_rd_en", int'(ifc.fifo_rd_en), 0);
        rst = 1'b0;
        bad_line = 0; bad_busy = 0;
        repeat (150) begin
            @(negedge clk);
            if (serial_out !== 1'b1) bad_line++;
            if (busy !== 1'b0) bad_busy++;
        end
        chk("postrst_line_low_cycles", bad_line, 0);
        chk("postrst_busy_cycles", bad_busy, 0);
        chk("postrst_fifo_empty", int'(ifc.fifo_empty), 1);
        dec_en = 1'b1;
        r0 = rd_cnt;
        push(8'h42);
        exp_q.push_back(8'h42);
        wait_pop("rst42", 20);
        check_frame("rst42", frame_of(8'h42), -1);
        repeat (5) @(negedge clk);
        chk("rst42_rd_pulses", rd_cnt - r0, 1);
        cmp_decoded("reset");

        // Randomized pushes with random enable gating
        r0 = rd_cnt;
        pushed = 0;
        for (int it = 0; it < 15; it++) begin
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) begin
                rb = 8'($urandom);
                push(rb);
                exp_q.push_back(rb);
                pushed++;
            end
            repeat ($urandom_range(0, 250)) begin
                @(negedge clk);
                enable = ($urandom_range(0, 3) != 0);
            end
        end
        enable = 1'b1;
        bad_rd = 1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (ifc.fifo_empty && !busy) begin
                bad_rd = 0;
                break;
            end
        end
        chk("random_drain_timeout", bad_rd, 0);
        repeat (5) @(negedge clk);
        chk("random_rd_pulses", rd_cnt - r0, pushed);
        cmp_decoded("random");

        chk("protocol_violations", proto_err, 0);
        chk("decoder_framing_errors", dec_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
